generic_acc_window: RTL and testbench

GENERIC_ACC_WINDOW -- requirements
Module: generic_acc_window

---
 rtl/generic_acc_pkg.sv | 13 +
 rtl/pair_add_reg.sv | 29 ++
 rtl/generic_acc_window.sv | 129 ++++++++++++
 tb/tb_generic_acc_window.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/generic_acc_pkg.sv
// Shared state encoding and default widths for the windowed accumulator.
package generic_acc_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } acc_state_t;

  localparam int unsigned DEF_IN_W    = 21;
  localparam int unsigned DEF_ACC_W   = 32;
  localparam int unsigned DEF_WIN_LEN = 16;

endpackage

// File: rtl/pair_add_reg.sv
// Registered, enabled adder: sum <= A+B and valid <= en on each rising edge.
// Ports: clk, rst (async, active-high), en, A, B -> sum (IN_W+1 bits), valid.
module pair_add_reg
  import generic_acc_pkg::*;
#(
  parameter int unsigned IN_W = DEF_IN_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [IN_W-1:0] A,
  input  logic [IN_W-1:0] B,
  output logic [IN_W:0]   sum,
  output logic            valid
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum   <= '0;
      valid <= 1'b0;
    end else begin
      valid <= en;
      if (en) begin
        sum <= {1'b0, A} + {1'b0, B};
      end
    end
  end

endmodule

// File: rtl/generic_acc_window.sv
// Two-stage windowed accumulator: stage 1 registers A+B, stage 2 sums
// WIN_LEN accepted samples and publishes the window result on acc_out.
// Ports: clk, rst (async, active-high), en, clr, in_valid, A, B ->
//        acc_out, out_valid, ovf, busy.
module generic_acc_window
  import generic_acc_pkg::*;
#(
  parameter int unsigned IN_W     = DEF_IN_W,
  parameter int unsigned ACC_W    = DEF_ACC_W,
  parameter int unsigned WIN_LEN  = DEF_WIN_LEN,
  parameter int unsigned SATURATE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             in_valid,
  input  logic [IN_W-1:0]  A,
  input  logic [IN_W-1:0]  B,
  output logic [ACC_W-1:0] acc_out,
  output logic             out_valid,
  output logic             ovf,
  output logic             busy
);

  localparam int unsigned CNT_W = $clog2(WIN_LEN + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIN_LEN - 1);

  generate
    if (ACC_W < IN_W + 1) begin : g_bad_acc_w
      $error("generic_acc_window: ACC_W must be at least IN_W+1");
    end
    if (WIN_LEN < 1) begin : g_bad_win_len
      $error("generic_acc_window: WIN_LEN must be at least 1");
    end
  endgenerate

  logic             accept;
  logic [IN_W:0]    p;
  logic             p_valid;
  logic [ACC_W-1:0] acc, acc_nxt, step_sum;
  logic [ACC_W:0]   sum_ext;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             win_ovf, win_ovf_nxt, step_ovf;
  logic             done;
  acc_state_t       state, state_nxt;

  // clr suppresses acceptance so a sample offered alongside it is dropped.
  assign accept = en & in_valid & ~clr;

  pair_add_reg #(
    .IN_W(IN_W)
  ) u_stage1 (
    .clk  (clk),
    .rst  (rst),
    .en   (accept),
    .A    (A),
    .B    (B),
    .sum  (p),
    .valid(p_valid)
  );

  always_comb begin
    sum_ext     = {1'b0, acc} + (ACC_W + 1)'(p);
    step_ovf    = win_ovf | sum_ext[ACC_W];
    step_sum    = (SATURATE != 0 && sum_ext[ACC_W]) ? '1 : sum_ext[ACC_W-1:0];
    acc_nxt     = acc;
    cnt_nxt     = cnt;
    win_ovf_nxt = win_ovf;
    done        = 1'b0;
    if (clr) begin
      acc_nxt     = '0;
      cnt_nxt     = '0;
      win_ovf_nxt = 1'b0;
    end else if (p_valid) begin
      if (cnt == LAST_CNT) begin
        // Final sample goes straight to acc_out; the next window starts clean
        // on the same edge so there is no bubble between windows.
        done        = 1'b1;
        acc_nxt     = '0;
        cnt_nxt     = '0;
        win_ovf_nxt = 1'b0;
      end else begin
        acc_nxt     = step_sum;
        cnt_nxt     = cnt + CNT_W'(1);
        win_ovf_nxt = step_ovf;
      end
    end
  end

  // Next state mirrors next count / next p_valid (p_valid follows accept).
  always_comb begin
    state_nxt = IDLE;
    if (cnt_nxt != '0 || accept) begin
      state_nxt = FILL;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc       <= '0;
      cnt       <= '0;
      win_ovf   <= 1'b0;
      acc_out   <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      acc       <= acc_nxt;
      cnt       <= cnt_nxt;
      win_ovf   <= win_ovf_nxt;
      out_valid <= done;
      if (done) begin
        acc_out <= step_sum;
        ovf     <= step_ovf;
      end
    end
  end

  assign busy = (state == FILL);

endmodule

// File: tb/tb_generic_acc_window.sv
module tb_generic_acc_window;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       clr;
  logic       in_valid;
  logic [7:0] A;
  logic [7:0] B;

  logic [9:0] s_acc_out, w_acc_out;
  logic       s_out_valid, w_out_valid;
  logic       s_ovf, w_ovf;
  logic       s_busy, w_busy;

  generic_acc_window #(.IN_W(8), .ACC_W(10), .WIN_LEN(4), .SATURATE(1)) dut_sat (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .in_valid(in_valid), .A(A), .B(B),
    .acc_out(s_acc_out), .out_valid(s_out_valid), .ovf(s_ovf), .busy(s_busy)
  );

  generic_acc_window #(.IN_W(8), .ACC_W(10), .WIN_LEN(4), .SATURATE(0)) dut_wrap (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .in_valid(in_valid), .A(A), .B(B),
    .acc_out(w_acc_out), .out_valid(w_out_valid), .ovf(w_ovf), .busy(w_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int a;
    int b;
    bit en;
    bit vld;
    bit last;
    int s_acc;
    int s_ovf;
    int w_acc;
    int w_ovf;
  } vec_t;

  typedef struct {
    int due;
    int s_acc;
    int s_ovf;
    int w_acc;
    int w_ovf;
  } exp_t;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  exp_t sb[$];
  int   pulse_log[$];
  vec_t tbl[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic vec_t mk(input int a, input int b, input bit e, input bit v,
                              input bit last, input int sa, input int so,
                              input int wa, input int wo);
    vec_t r;
    r.a = a; r.b = b; r.en = e; r.vld = v; r.last = last;
    r.s_acc = sa; r.s_ovf = so; r.w_acc = wa; r.w_ovf = wo;
    return r;
  endfunction

  // Present one cycle of stimulus; a window-completing sample is due on
  // out_valid two cycles after the cycle it is presented in.
  task automatic apply(input vec_t r, input bit c);
    exp_t e;
    A = 8'(r.a); B = 8'(r.b); en = r.en; in_valid = r.vld; clr = c;
    if (r.last) begin
      e.due = cyc + 2; e.s_acc = r.s_acc; e.s_ovf = r.s_ovf;
      e.w_acc = r.w_acc; e.w_ovf = r.w_ovf;
      sb.push_back(e);
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) apply(mk(0, 0, 1'b1, 1'b0, 1'b0, 0, 0, 0, 0), 1'b0);
  endtask

  task automatic smp(input int a, input int b);
    apply(mk(a, b, 1'b1, 1'b1, 1'b0, 0, 0, 0, 0), 1'b0);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (s_out_valid || w_out_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_pulse", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          pulse_log.push_back(cyc);
          chk("pulse_cycle", cyc, e.due);
          chk("sat_valid", int'(s_out_valid), 1);
          chk("wrap_valid", int'(w_out_valid), 1);
          chk("sat_acc", int'(s_acc_out), e.s_acc);
          chk("sat_ovf", int'(s_ovf), e.s_ovf);
          chk("wrap_acc", int'(w_acc_out), e.w_acc);
          chk("wrap_ovf", int'(w_ovf), e.w_ovf);
        end
      end else if (sb.size() > 0 && sb[0].due < cyc) begin
        void'(sb.pop_front());
        chk("missing_pulse", 0, 1);
      end
    end
  end

  task automatic chk_zero(input string tag);
    chk({tag, "_sat_acc"}, int'(s_acc_out), 0);
    chk({tag, "_sat_valid"}, int'(s_out_valid), 0);
    chk({tag, "_sat_ovf"}, int'(s_ovf), 0);
    chk({tag, "_sat_busy"}, int'(s_busy), 0);
    chk({tag, "_wrap_acc"}, int'(w_acc_out), 0);
    chk({tag, "_wrap_valid"}, int'(w_out_valid), 0);
    chk({tag, "_wrap_ovf"}, int'(w_ovf), 0);
    chk({tag, "_wrap_busy"}, int'(w_busy), 0);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; clr = 1'b0; in_valid = 1'b0; A = '0; B = '0;

    // 1..4 with an in_valid bubble in the middle
    tbl.push_back(mk(1, 0, 1, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(2, 0, 1, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(9, 9, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(3, 0, 1, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(4, 0, 1, 1, 1, 10, 0, 10, 0));
    // overflow: saturate to 1023, wrap to 2040 mod 1024 = 1016
    for (int i = 0; i < 3; i++) tbl.push_back(mk(255, 255, 1, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(255, 255, 1, 1, 1, 1023, 1, 1016, 1));
    // two back-to-back windows of 1+1, overflow flag must not carry over
    for (int w = 0; w < 2; w++) begin
      for (int i = 0; i < 3; i++) tbl.push_back(mk(1, 1, 1, 1, 0, 0, 0, 0, 0));
      tbl.push_back(mk(1, 1, 1, 1, 1, 8, 0, 8, 0));
    end
    // en=0 on the 2nd and 3rd offers; window completes on the 6th offer
    tbl.push_back(mk(5, 0, 1, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(5, 0, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(5, 0, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(5, 0, 1, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(5, 0, 1, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(5, 0, 1, 1, 1, 20, 0, 20, 0));

    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    rst = 1'b0;

    foreach (tbl[i]) apply(tbl[i], 1'b0);
    idle(3);

    // clr after two samples of 7; a sample offered with clr is dropped
    smp(7, 0);
    smp(7, 0);
    apply(mk(9, 9, 1, 1, 0, 0, 0, 0, 0), 1'b1);
    chk("clr_sat_busy", int'(s_busy), 0);
    chk("clr_wrap_busy", int'(w_busy), 0);
    chk("clr_sat_hold", int'(s_acc_out), 20);
    chk("clr_wrap_hold", int'(w_acc_out), 20);
    smp(1, 0);
    chk("fill_sat_busy", int'(s_busy), 1);
    smp(1, 0);
    smp(1, 0);
    chk("pre_sat_hold", int'(s_acc_out), 20);
    apply(mk(1, 0, 1, 1, 1, 4, 0, 4, 0), 1'b0);
    chk("mid_sat_hold", int'(s_acc_out), 20);
    idle(3);
    chk("post_sat_hold", int'(s_acc_out), 4);
    chk("post_wrap_hold", int'(w_acc_out), 4);

    // asynchronous reset between edges, mid-window
    smp(2, 0);
    smp(2, 0);
    en = 1'b0; in_valid = 1'b0;
    #1 rst = 1'b1;
    #1 chk_zero("async_rst");
    #1 rst = 1'b0;
    @(posedge clk); #1;
    smp(2, 0);
    smp(2, 0);
    smp(2, 0);
    apply(mk(2, 0, 1, 1, 1, 8, 0, 8, 0), 1'b0);
    idle(4);

    chk("sb_drained", sb.size(), 0);
    chk("pulse_count", pulse_log.size(), 7);
    if (pulse_log.size() >= 4) chk("b2b_gap", pulse_log[3] - pulse_log[2], 4);
    chk("end_sat_busy", int'(s_busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
